div_sequencer: RTL and testbench

//  Multi-cycle DIV/DIVU engine and its controlling FSM for the EX stage.
//  - Sits beside the single-cycle ALU.
//  - Accepts a divide request from EX and stalls the pipeline while iterating.
//  - Returns {remainder, quotient} for the HI/LO write.
//  - Radix-2 restoring divider: one quotient bit per cycle.

---
 rtl/div_sequencer.sv | 138 +++++++++++++
 tb/tb_div_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring DIV/DIVU engine with its controlling FSM.
// Stalls IF..EX while iterating and returns {remainder, quotient} for the HI/LO write.
module div_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opa,
  input  logic [DATA_W-1:0]   opb,
  input  logic                annul,
  output logic                stall_req,
  output logic                ready,
  output logic [2*DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DZERO, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     shifted, trial;
  logic [DATA_W-1:0]   rem_nx, quo_nx, q_fix, r_fix;

  always_comb begin
    a_neg   = signed_div & opa[DATA_W-1];
    b_neg   = signed_div & opb[DATA_W-1];
    abs_a   = a_neg ? -opa : opa;
    abs_b   = b_neg ? -opb : opb;
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_nx  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_nx  = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
    q_fix   = qneg_q ? -quo_nx : quo_nx;
    r_fix   = rneg_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          cnt_d  = '0;
          rem_d  = '0;
          dvs_d  = abs_b;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (opb == '0) begin
            quo_d   = opa;
            state_d = DZERO;
          end else begin
            quo_d   = abs_a;
            state_d = RUN;
          end
        end
      end
      DZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          result_d = {quo_q, {DATA_W{1'b1}}};
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      RUN: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_d = {r_fix, q_fix};
            ready_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the order.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign stall_req = ((state_q == IDLE) && start && !annul) ||
                     (state_q == DZERO) || (state_q == RUN);
  assign ready     = ready_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: latency, signed/unsigned results,
// divide-by-zero, annul, held start through DONE and synchronous reset mid-run.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] opa, opb;
  logic        stall_req, ready;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  div_sequencer #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opa(opa), .opb(opb), .annul(annul),
    .stall_req(stall_req), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue an operation in the current (IDLE) cycle T and follow it to the ready pulse
  // at T+lat. start stays high through DONE; operands are scrambled after capture.
  task automatic run_op(input logic sdiv, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string tag);
    start = 1'b1; signed_div = sdiv; opa = a; opb = b;
    #1;
    check({tag, "_stall_T"}, 64'(stall_req), 64'd1);
    check({tag, "_ready_T"}, 64'(ready), 64'd0);
    for (int k = 1; k < lat; k++) begin
      step();
      if (k == 1) begin
        opa = ~a; opb = b + 32'd3; signed_div = ~sdiv;
      end
      #1;
      check($sformatf("%s_stall_%0d", tag, k), 64'(stall_req), 64'd1);
      check($sformatf("%s_ready_%0d", tag, k), 64'(ready), 64'd0);
    end
    step();
    #1;
    check({tag, "_ready_done"}, 64'(ready), 64'd1);
    check({tag, "_stall_done"}, 64'(stall_req), 64'd0);
    check({tag, "_result"}, result, exp);
  endtask

  // Pipeline advances: drop start, confirm a single ready pulse, land in IDLE.
  task automatic gap(input string tag);
    step();
    start = 1'b0;
    #1;
    check({tag, "_ready_after"}, 64'(ready), 64'd0);
    check({tag, "_stall_after"}, 64'(stall_req), 64'd0);
    step();
  endtask

  initial begin
    int          pulses;
    logic [63:0] prev;

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opa = '0; opb = '0;
    step(); step();
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    step();

    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
    gap("divu_100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
    gap("div_m7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
    gap("div_7_m2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, "div_min_m1");
    gap("div_min_m1");
    run_op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}, 33, "div_m8_m3");
    gap("div_m8_m3");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, "divu_max_1");
    gap("divu_max_1");
    run_op(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, 33, "divu_3_10");
    gap("divu_3_10");

    run_op(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2, "divu_5_0");
    gap("divu_5_0");
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2, "div_m5_0");
    gap("div_m5_0");

    // Annul in the 10th RUN cycle: back to IDLE, no ready, result untouched.
    prev = {32'hFFFF_FFFB, 32'hFFFF_FFFF};
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    for (int k = 1; k <= 10; k++) step();
    annul = 1'b1;
    #1;
    check("annul_stall_run", 64'(stall_req), 64'd1);
    step();
    start = 1'b0; annul = 1'b0;
    #1;
    check("annul_stall_idle", 64'(stall_req), 64'd0);
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, prev);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (ready) pulses++;
    end
    check("annul_no_pulse", 64'(pulses), 64'd0);
    check("annul_result_hold", result, prev);
    step();
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "divu_9_3");

    // start held through DONE; the next instruction is another DIV accepted in IDLE.
    step();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "b2b_div");
    gap("b2b_div");

    // Synchronous reset in the middle of RUN.
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd9;
    for (int k = 1; k <= 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_stall_start1", 64'(stall_req), 64'd1);
    start = 1'b0;
    #1;
    check("rst_mid_stall_start0", 64'(stall_req), 64'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
